fpu_div_exp_ctl: RTL and testbench
==================================

# fpu_div_exp_ctl

Stage sequencer for the divide-pipe exponent datapath. It accepts one divide request at a time and walks the exponent datapath through its stages:

- operand capture
- bias add
- exponent subtract
- two normalization adjustments
- the mantissa iteration window
- back-end adjust, decrement and round stages

It drives every stage, select and load strobe of the exponent datapath and the divide-pipe clock enable. It reports completion to the FPU output arbiter.

## Interface

Parameters:
- ITER_DBL, 55, iteration-window length in cycles for double divide
- ITER_SNG, 26, iteration-window length in cycles for single divide
- CNT_W, 6, iteration counter width; must hold max(ITER_DBL, ITER_SNG)

Ports (clock and reset first):
- rclk  in  1  global clock; one clock; all state updates on rising edge
- arst_l  in  1  reset, asynchronous, active-low
- div_req  in  1  divide request valid
- div_req_dbl  in  1  request is double (1) or single (0); sampled with div_req
- div_rdy  out  1  high only in IDLE; request accepted when div_req & div_rdy
- div_kill  in  1  flush; aborts the operation in flight
- div_special  in  2  special-result code from the fraction pipe, valid in D2: 00 none, 01 zero, 10 0x0835, 11 0x0118
- d1stg_step  out  1  operand exponent capture strobe
- div_expadd1_in1_dbl, div_expadd1_in1_sng  out  1 each  bias-add selects
- div_expadd1_in2_exp_in2_dbl, div_expadd1_in2_exp_in2_sng  out  1 each  subtract selects
- d234stg_fdiv, d3stg_fdiv, d4stg_fdiv  out  1 each  front-end stage flags
- div_exp1_expadd1, div_exp1_zero, div_exp1_0835, div_exp1_0118, div_exp1_load  out  1 each  exp1 mux selects and load enable
- d5stg_fdiva, d5stg_fdivd, d5stg_fdivs, d6stg_fdiv, d7stg_fdiv, d7stg_fdivd  out  1 each  back-end stage flags
- div_expadd2_in1_exp_out, div_exp_out_expadd2, div_exp_out_exp_out, div_exp_out_load  out  1 each  back-end selects and load
- fdiv_clken_l  out  1  divide-pipe clock enable, active-low
- div_done  out  1  one-cycle completion pulse
- div_done_dbl  out  1  precision of the completed operation; valid with div_done

## Operation

- States: IDLE, D1, D2, SUB, NRM1, NRM2, ITER, D5, D6, D7. One-hot or encoded, implementer's choice. All outputs are decoded from registered state and the registered precision bit `dbl`.
- IDLE: div_rdy=1. On accept, capture `dbl`=div_req_dbl and go to D1.
- D1: d1stg_step=1.
- D2:
  - Assert in1_dbl or in1_sng per `dbl`, and div_exp1_load=1.
  - If div_special==00: div_exp1_expadd1=1; next state SUB.
  - Otherwise assert exactly the matching div_exp1_zero/0835/0118; next state D5, skipping SUB through ITER.
- SUB: d234stg_fdiv=1, in2_exp_in2_dbl or in2_exp_in2_sng per `dbl`, div_exp1_expadd1=1, div_exp1_load=1.
- NRM1: d234stg_fdiv=1, d3stg_fdiv=1, div_exp1_expadd1=1, div_exp1_load=1.
- NRM2: d234stg_fdiv=1, d4stg_fdiv=1, div_exp1_expadd1=1, div_exp1_load=1.
- ITER:
  - The counter loads ITER_DBL-1 or ITER_SNG-1 on NRM2→ITER and decrements each cycle.
  - Leave for D5 when the counter reaches 0, so ITER lasts exactly ITER_DBL or ITER_SNG cycles.
  - No datapath strobes are asserted in ITER.
- D5: d5stg_fdiva=1, d5stg_fdivd=`dbl`, d5stg_fdivs=~`dbl`, div_exp_out_expadd2=1, div_exp_out_load=1.
- D6: d6stg_fdiv=1, div_expadd2_in1_exp_out=1, div_exp_out_expadd2=1, div_exp_out_load=1.
- D7:
  - d7stg_fdiv=1, d7stg_fdivd=`dbl`, div_expadd2_in1_exp_out=1, div_exp_out_expadd2=1, div_exp_out_exp_out=1, div_exp_out_load=1.
  - Next state IDLE; div_done registered high for the following cycle, with div_done_dbl=`dbl`.
- Select exclusivity: at most one div_exp1_* select is high in any cycle. In1 and in2 selects are never simultaneously high.
- fdiv_clken_l = ~(div_req | state≠IDLE | div_done).
- div_kill: from any state, next state is IDLE and the counter clears. No div_done is generated. Kill takes priority over accept in the same cycle.

## Timing

- Reset (arst_l=0, async): state IDLE, counter 0, `dbl` 0, div_done 0, div_rdy 1, all strobes 0, fdiv_clken_l 1.
- Reset deassertion mid-operation restarts cleanly from IDLE.
- Accept in cycle T gives: D1 at T+1, D2 at T+2, SUB T+3, NRM1 T+4, NRM2 T+5, ITER T+6…T+5+N, D5 T+6+N, D6 T+7+N, D7 T+8+N, div_done T+9+N.
  - N = ITER_DBL for double (done at T+64 with defaults).
  - N = ITER_SNG for single (done at T+35).
- Special path: D5 at T+3, done at T+6.
- A new request may be accepted in the div_done cycle, since the FSM is in IDLE.
- Requests while busy are not accepted; the requester holds div_req.

## Test plan

- Reset asserted mid-ITER → next edge shows all outputs at reset values; req after deassert is accepted normally.
- Double request at T=0 → d1stg_step at 1; exp1_load at 2–5; 55 ITER cycles; exp_out_load at 61–63; div_done=1, div_done_dbl=1 at 64.
- Single request → d5stg_fdivs=1 at 32; div_done at 35 with div_done_dbl=0.
- div_special=10 in D2 → div_exp1_0835 & div_exp1_load at 2; D5 at 3; div_done at 6; no d234stg_fdiv ever.
- div_kill in ITER cycle 10 → IDLE next cycle, no div_done, div_rdy=1; a back-to-back request completes with full latency.
- Request held high across completion → second accept in the div_done cycle; fdiv_clken_l stays 0 throughout both operations.

Source files
------------

// File: rtl/fpu_div_exp_ctl.sv
// Stage sequencer for the divide-pipe exponent datapath: walks one divide
// request through capture, bias add, subtract, normalize, iterate and back-end stages.
module fpu_div_exp_ctl #(
  parameter int ITER_DBL = 55,
  parameter int ITER_SNG = 26,
  parameter int CNT_W    = 6
) (
  input  logic       rclk,
  input  logic       arst_l,
  input  logic       div_req,
  input  logic       div_req_dbl,
  output logic       div_rdy,
  input  logic       div_kill,
  input  logic [1:0] div_special,
  output logic       d1stg_step,
  output logic       div_expadd1_in1_dbl,
  output logic       div_expadd1_in1_sng,
  output logic       div_expadd1_in2_exp_in2_dbl,
  output logic       div_expadd1_in2_exp_in2_sng,
  output logic       d234stg_fdiv,
  output logic       d3stg_fdiv,
  output logic       d4stg_fdiv,
  output logic       div_exp1_expadd1,
  output logic       div_exp1_zero,
  output logic       div_exp1_0835,
  output logic       div_exp1_0118,
  output logic       div_exp1_load,
  output logic       d5stg_fdiva,
  output logic       d5stg_fdivd,
  output logic       d5stg_fdivs,
  output logic       d6stg_fdiv,
  output logic       d7stg_fdiv,
  output logic       d7stg_fdivd,
  output logic       div_expadd2_in1_exp_out,
  output logic       div_exp_out_expadd2,
  output logic       div_exp_out_exp_out,
  output logic       div_exp_out_load,
  output logic       fdiv_clken_l,
  output logic       div_done,
  output logic       div_done_dbl,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_D1, S_D2, S_SUB, S_NRM1, S_NRM2, S_ITER, S_D5, S_D6, S_D7
  } state_t;

  localparam logic [CNT_W-1:0] LP_DBL_LAST = CNT_W'(ITER_DBL - 1);
  localparam logic [CNT_W-1:0] LP_SNG_LAST = CNT_W'(ITER_SNG - 1);

  state_t           r_state;
  logic             r_dbl;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_done_dbl;

  // Handshake: a request transfers on any rising edge where div_req & div_rdy
  // and div_kill is low; the requester holds div_req until that happens.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state    <= S_IDLE;
      r_dbl      <= 1'b0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_done_dbl <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (div_kill) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (div_req) begin
            r_state <= S_D1;
            r_dbl   <= div_req_dbl;
          end
          S_D1:   r_state <= S_D2;
          S_D2:   r_state <= (div_special == 2'b00) ? S_SUB : S_D5;
          S_SUB:  r_state <= S_NRM1;
          S_NRM1: r_state <= S_NRM2;
          S_NRM2: begin
            r_state <= S_ITER;
            r_cnt   <= r_dbl ? LP_DBL_LAST : LP_SNG_LAST;
          end
          S_ITER: begin
            if (r_cnt == '0) r_state <= S_D5;
            else             r_cnt   <= r_cnt - 1'b1;
          end
          S_D5:   r_state <= S_D6;
          S_D6:   r_state <= S_D7;
          S_D7: begin
            r_state    <= S_IDLE;
            r_done     <= 1'b1;
            r_done_dbl <= r_dbl;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  logic w_d2, w_sub, w_nrm1, w_nrm2, w_d5, w_d6, w_d7, w_front;

  assign w_d2    = (r_state == S_D2);
  assign w_sub   = (r_state == S_SUB);
  assign w_nrm1  = (r_state == S_NRM1);
  assign w_nrm2  = (r_state == S_NRM2);
  assign w_d5    = (r_state == S_D5);
  assign w_d6    = (r_state == S_D6);
  assign w_d7    = (r_state == S_D7);
  assign w_front = w_sub | w_nrm1 | w_nrm2;

  assign dbg_state  = r_state;
  assign div_rdy    = (r_state == S_IDLE);
  assign d1stg_step = (r_state == S_D1);

  assign div_expadd1_in1_dbl         = w_d2 & r_dbl;
  assign div_expadd1_in1_sng         = w_d2 & ~r_dbl;
  assign div_expadd1_in2_exp_in2_dbl = w_sub & r_dbl;
  assign div_expadd1_in2_exp_in2_sng = w_sub & ~r_dbl;

  assign d234stg_fdiv = w_front;
  assign d3stg_fdiv   = w_nrm1;
  assign d4stg_fdiv   = w_nrm2;

  // D2 picks the exp1 source: the bias-add result, or a forced special constant.
  assign div_exp1_expadd1 = (w_d2 & (div_special == 2'b00)) | w_front;
  assign div_exp1_zero    = w_d2 & (div_special == 2'b01);
  assign div_exp1_0835    = w_d2 & (div_special == 2'b10);
  assign div_exp1_0118    = w_d2 & (div_special == 2'b11);
  assign div_exp1_load    = w_d2 | w_front;

  assign d5stg_fdiva = w_d5;
  assign d5stg_fdivd = w_d5 & r_dbl;
  assign d5stg_fdivs = w_d5 & ~r_dbl;
  assign d6stg_fdiv  = w_d6;
  assign d7stg_fdiv  = w_d7;
  assign d7stg_fdivd = w_d7 & r_dbl;

  assign div_expadd2_in1_exp_out = w_d6 | w_d7;
  assign div_exp_out_expadd2     = w_d5 | w_d6 | w_d7;
  assign div_exp_out_exp_out     = w_d7;
  assign div_exp_out_load        = w_d5 | w_d6 | w_d7;

  assign fdiv_clken_l = ~(div_req | ~div_rdy | r_done);
  assign div_done     = r_done;
  assign div_done_dbl = r_done_dbl;

endmodule

// File: tb/tb_fpu_div_exp_ctl.sv
// Bench for fpu_div_exp_ctl: cycle-offset reference model for every strobe plus
// a completion scoreboard; directed scenarios followed by random traffic.
`timescale 1ns/1ps
module tb_fpu_div_exp_ctl;
  localparam int ITER_DBL = 55;
  localparam int ITER_SNG = 26;
  localparam int CNT_W    = 6;
  localparam int VW       = 25;
  localparam int QW       = 33;

  logic       rclk = 1'b0;
  logic       arst_l, div_req, div_req_dbl, div_kill;
  logic [1:0] div_special;
  logic       div_rdy, d1stg_step;
  logic       div_expadd1_in1_dbl, div_expadd1_in1_sng;
  logic       div_expadd1_in2_exp_in2_dbl, div_expadd1_in2_exp_in2_sng;
  logic       d234stg_fdiv, d3stg_fdiv, d4stg_fdiv;
  logic       div_exp1_expadd1, div_exp1_zero, div_exp1_0835, div_exp1_0118, div_exp1_load;
  logic       d5stg_fdiva, d5stg_fdivd, d5stg_fdivs, d6stg_fdiv, d7stg_fdiv, d7stg_fdivd;
  logic       div_expadd2_in1_exp_out, div_exp_out_expadd2, div_exp_out_exp_out, div_exp_out_load;
  logic       fdiv_clken_l, div_done, div_done_dbl;
  logic [3:0] dbg_state;

  fpu_div_exp_ctl #(.ITER_DBL(ITER_DBL), .ITER_SNG(ITER_SNG), .CNT_W(CNT_W)) dut (
    .rclk(rclk), .arst_l(arst_l), .div_req(div_req), .div_req_dbl(div_req_dbl),
    .div_rdy(div_rdy), .div_kill(div_kill), .div_special(div_special),
    .d1stg_step(d1stg_step),
    .div_expadd1_in1_dbl(div_expadd1_in1_dbl), .div_expadd1_in1_sng(div_expadd1_in1_sng),
    .div_expadd1_in2_exp_in2_dbl(div_expadd1_in2_exp_in2_dbl),
    .div_expadd1_in2_exp_in2_sng(div_expadd1_in2_exp_in2_sng),
    .d234stg_fdiv(d234stg_fdiv), .d3stg_fdiv(d3stg_fdiv), .d4stg_fdiv(d4stg_fdiv),
    .div_exp1_expadd1(div_exp1_expadd1), .div_exp1_zero(div_exp1_zero),
    .div_exp1_0835(div_exp1_0835), .div_exp1_0118(div_exp1_0118), .div_exp1_load(div_exp1_load),
    .d5stg_fdiva(d5stg_fdiva), .d5stg_fdivd(d5stg_fdivd), .d5stg_fdivs(d5stg_fdivs),
    .d6stg_fdiv(d6stg_fdiv), .d7stg_fdiv(d7stg_fdiv), .d7stg_fdivd(d7stg_fdivd),
    .div_expadd2_in1_exp_out(div_expadd2_in1_exp_out), .div_exp_out_expadd2(div_exp_out_expadd2),
    .div_exp_out_exp_out(div_exp_out_exp_out), .div_exp_out_load(div_exp_out_load),
    .fdiv_clken_l(fdiv_clken_l), .div_done(div_done), .div_done_dbl(div_done_dbl),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 rclk = ~rclk;

  int cyc = 0;
  always @(posedge rclk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  int            checks   = 0;
  int            failures = 0;
  bit            m_busy   = 1'b0;
  bit            m_dbl    = 1'b0;
  int            m_acc    = 0;
  int            m_n      = 0;
  int            m_end    = 0;
  logic [1:0]    m_sp     = 2'b00;
  logic [QW-1:0] exp_q[$];

  // Expected strobes as a function of cycles elapsed since accept.
  function automatic logic [VW-1:0] exp_vec(input bit busy, input int k, input bit dbl,
                                            input logic [1:0] sp, input int n,
                                            input bit req, input bit done_now);
    bit rdy = 0, d1 = 0, i1d = 0, i1s = 0, i2d = 0, i2s = 0, d234 = 0, d3 = 0, d4 = 0;
    bit e_add = 0, e_z = 0, e_35 = 0, e_18 = 0, e_ld = 0;
    bit d5a = 0, d5d = 0, d5s = 0, d6 = 0, d7 = 0, d7d = 0;
    bit a2 = 0, o_add = 0, o_out = 0, o_ld = 0, clkl;
    int d5k;
    d5k = (sp != 2'b00) ? 3 : 6 + n;
    if (!busy) rdy = 1;
    else if (k == 1) d1 = 1;
    else if (k == 2) begin
      i1d = dbl; i1s = !dbl; e_ld = 1;
      case (sp)
        2'b00:   e_add = 1;
        2'b01:   e_z   = 1;
        2'b10:   e_35  = 1;
        default: e_18  = 1;
      endcase
    end else if (sp == 2'b00 && k >= 3 && k <= 5) begin
      d234 = 1; e_add = 1; e_ld = 1;
      i2d = (k == 3) && dbl; i2s = (k == 3) && !dbl;
      d3 = (k == 4); d4 = (k == 5);
    end else if (k == d5k) begin
      d5a = 1; d5d = dbl; d5s = !dbl; o_add = 1; o_ld = 1;
    end else if (k == d5k + 1) begin
      d6 = 1; a2 = 1; o_add = 1; o_ld = 1;
    end else if (k == d5k + 2) begin
      d7 = 1; d7d = dbl; a2 = 1; o_add = 1; o_out = 1; o_ld = 1;
    end
    clkl = !(req || busy || done_now);
    return {rdy, d1, i1d, i1s, i2d, i2s, d234, d3, d4, e_add, e_z, e_35, e_18, e_ld,
            d5a, d5d, d5s, d6, d7, d7d, a2, o_add, o_out, o_ld, clkl};
  endfunction

  always @(posedge rclk or negedge arst_l) begin : model
    int k;
    if (!arst_l) begin
      m_busy = 1'b0;
      exp_q.delete();
    end else begin
      k = cyc - m_acc;
      if (m_busy && k == 2) begin
        m_sp  = div_special;
        m_end = (div_special != 2'b00) ? 5 : 8 + m_n;
        exp_q.push_back({m_dbl, 32'(m_acc + m_end + 1)});
      end
      if (div_kill) begin
        m_busy = 1'b0;
        exp_q.delete();
      end else if (m_busy && k > 2 && k == m_end) begin
        m_busy = 1'b0;
      end else if (!m_busy && div_req) begin
        m_busy = 1'b1;
        m_acc  = cyc;
        m_dbl  = div_req_dbl;
        m_n    = div_req_dbl ? ITER_DBL : ITER_SNG;
        m_sp   = 2'b00;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge rclk) begin : monitor
    logic [VW-1:0] e, a;
    logic [QW-1:0] ent;
    bit            busy, due;
    int            k;
    logic [1:0]    sp;
    ent  = '0;
    busy = arst_l && m_busy;
    k    = cyc - m_acc;
    sp   = (k == 2) ? div_special : m_sp;
    due  = (exp_q.size() > 0) && (exp_q[0][31:0] == 32'(cyc));
    e = exp_vec(busy, k, m_dbl, sp, m_n, div_req === 1'b1, due);
    a = {div_rdy, d1stg_step, div_expadd1_in1_dbl, div_expadd1_in1_sng,
         div_expadd1_in2_exp_in2_dbl, div_expadd1_in2_exp_in2_sng,
         d234stg_fdiv, d3stg_fdiv, d4stg_fdiv,
         div_exp1_expadd1, div_exp1_zero, div_exp1_0835, div_exp1_0118, div_exp1_load,
         d5stg_fdiva, d5stg_fdivd, d5stg_fdivs, d6stg_fdiv, d7stg_fdiv, d7stg_fdivd,
         div_expadd2_in1_exp_out, div_exp_out_expadd2, div_exp_out_exp_out, div_exp_out_load,
         fdiv_clken_l};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL strobes cyc=%0d k=%0d dut_state=%0d got=%b exp=%b", cyc, k, dbg_state, a, e);
    end
    if (div_done !== 1'b0 || due) begin
      checks++;
      if (due) ent = exp_q.pop_front();
      if (!(div_done === 1'b1 && due && div_done_dbl === ent[32])) begin
        failures++;
        $display("FAIL done cyc=%0d got done=%b dbl=%b exp done=%b dbl=%b",
                 cyc, div_done, div_done_dbl, due, ent[32]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  initial begin
    arst_l = 1'b0; div_req = 1'b0; div_req_dbl = 1'b0; div_kill = 1'b0; div_special = 2'b00;
    tick(); tick(); tick();
    arst_l = 1'b1;
    tick();

    // double request
    div_req = 1'b1; div_req_dbl = 1'b1; tick();
    div_req = 1'b0; repeat (70) tick();
    // single request
    div_req = 1'b1; div_req_dbl = 1'b0; tick();
    div_req = 1'b0; repeat (40) tick();
    // special result 0x0835
    div_req = 1'b1; div_req_dbl = 1'b0; div_special = 2'b10; tick();
    div_req = 1'b0; repeat (10) tick();
    div_special = 2'b00;
    // kill in the tenth iteration cycle, then a back-to-back request
    div_req = 1'b1; div_req_dbl = 1'b1; tick();
    div_req = 1'b0; repeat (14) tick();
    div_kill = 1'b1; tick();
    div_kill = 1'b0; div_req = 1'b1; div_req_dbl = 1'b0; tick();
    div_req = 1'b0; repeat (40) tick();
    // request held across completion
    div_req = 1'b1; div_req_dbl = 1'b1; repeat (70) tick();
    div_req = 1'b0; repeat (70) tick();
    // reset mid-iteration, then a fresh request
    div_req = 1'b1; div_req_dbl = 1'b1; tick();
    div_req = 1'b0; repeat (20) tick();
    arst_l = 1'b0; tick(); tick();
    arst_l = 1'b1; div_req = 1'b1; div_req_dbl = 1'b0; tick();
    div_req = 1'b0; repeat (40) tick();

    // random traffic
    repeat (4000) begin
      div_req     = ($urandom_range(0, 3) != 0);
      div_req_dbl = 1'($urandom_range(0, 1));
      div_special = ($urandom_range(0, 1) != 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      div_kill    = ($urandom_range(0, 149) == 0);
      arst_l      = ($urandom_range(0, 1999) != 0);
      tick();
    end
    arst_l = 1'b1; div_req = 1'b0; div_kill = 1'b0; div_special = 2'b00;
    repeat (80) tick();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
